// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the boot-time program loader.
//   loader_state_t  : loader FSM states (CHK is reachable only with
//                     IMEM_LOADER_CHECKSUM_EN defined)
//   DEFAULT_N       : default instruction word width in bits
//   BYTES_PER_WORD  : stream bytes packed into one default-width word
//   CHKSUM_W        : width of the running payload checksum
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_CHK,
    ST_DONE
  } loader_state_t;

  localparam int DEFAULT_N      = 32;
  localparam int BYTES_PER_WORD = DEFAULT_N / 8;
  localparam int CHKSUM_W       = 8;

endpackage

// File: rtl/imem_loader_word_packer.sv
// word_packer: assembles stream bytes into an N-bit word, little-endian.
//   Byte k of a word lands in word[8k+7:8k]; the index wraps to 0 after the
//   last byte so the next word starts cleanly.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-low reset (clears index and word)
//   clr        in   force the byte index back to 0 (word contents kept)
//   byte_en    in   store data_byte at the current index and advance
//   data_byte  in   8-bit stream byte
//   word       out  N-bit assembled word
//   last_byte  out  current index is the final byte of the word
module word_packer
  import imem_loader_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         byte_en,
  input  logic [7:0]   data_byte,
  output logic [N-1:0] word,
  output logic         last_byte
);

  localparam int BPW   = N / 8;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

  logic [IDX_W-1:0] idx;

  assign last_byte = (idx == IDX_W'(BPW - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (byte_en) begin
      word[8*idx +: 8] <= data_byte;
      idx              <= last_byte ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader (instruction-memory writer side).
//   Packs a valid/ready byte stream into N-bit little-endian words and writes
//   them to consecutive imem addresses from 0, holding the CPU while loading.
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN -- after the last word,
//   accept one checksum byte; err flags (payload sum + byte) mod 256 != 0.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-low reset
//   start       in   begin a load (honoured only in IDLE/DONE)
//   word_count  in   words to load, sampled on accepted start; clamps at 2**ADDR_W
//   s_data      in   stream byte
//   s_valid     in   s_data valid
//   s_ready     out  byte accepted this cycle when s_valid is high
//   we          out  imem write enable, one pulse per word
//   waddr       out  imem write address
//   wdata       out  imem write data
//   busy        out  load in progress
//   cpu_hold    out  CPU held in reset (equals busy)
//   done        out  load finished, held until the next accepted start
//   err         out  checksum mismatch, meaningful while done=1
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int N      = DEFAULT_N,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic [7:0]        s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              we,
  output logic [ADDR_W-1:0] waddr,
  output logic [N-1:0]      wdata,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  loader_state_t   state, state_next;
  logic [ADDR_W:0] words_left;
  logic            start_ok;
  logic            byte_en;
  logic            clr;
  logic            last_byte;

  word_packer #(.N(N)) u_packer (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .byte_en   (byte_en),
    .data_byte (s_data),
    .word      (wdata),
    .last_byte (last_byte)
  );

  assign cpu_hold = busy;

  always_ff @(posedge clk) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    s_ready    = 1'b0;
    we         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    byte_en    = 1'b0;
    clr        = 1'b0;
    start_ok   = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        done = (state == ST_DONE);
        if (start) begin
          start_ok   = 1'b1;
          clr        = 1'b1;
          state_next = (word_count == '0) ? ST_DONE : ST_RECV;
        end
      end
      ST_RECV: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        byte_en = s_valid;
        if (s_valid && last_byte) state_next = ST_WRITE;
      end
      ST_WRITE: begin
        we   = 1'b1;
        busy = 1'b1;
        clr  = 1'b1;
        if (words_left == (ADDR_W+1)'(1)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = ST_CHK;
`else
          state_next = ST_DONE;
`endif
        end else begin
          state_next = ST_RECV;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHK: begin
        s_ready = 1'b1;
        busy    = 1'b1;
        if (s_valid) state_next = ST_DONE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Address and remaining-word bookkeeping. waddr advances in the cycle after
  // each write, so after a full-depth load it wraps to 0 only once, at the end.
  always_ff @(posedge clk) begin
    if (!reset) begin
      waddr      <= '0;
      words_left <= '0;
    end else if (start_ok) begin
      waddr      <= '0;
      words_left <= (word_count > DEPTH) ? DEPTH : word_count;
    end else if (state == ST_WRITE) begin
      waddr      <= waddr + 1'b1;
      words_left <= words_left - 1'b1;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [CHKSUM_W-1:0] sum;
  logic [CHKSUM_W-1:0] chk_total;

  assign chk_total = sum + s_data;

  always_ff @(posedge clk) begin
    if (!reset) begin
      sum <= '0;
      err <= 1'b0;
    end else if (start_ok) begin
      sum <= '0;
      err <= 1'b0;
    end else begin
      if (byte_en) sum <= chk_total;
      if (state == ST_CHK && s_valid) err <= (chk_total != '0);
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader.
//   The reference model turns a byte list into the expected list of
//   (address, word) writes, the final address, the held data word, the error
//   flag and, for gap-free streams, the exact load duration in cycles.
module tb_imem_loader;

  localparam int N      = 32;
  localparam int ADDR_W = 8;
  localparam int BPW    = N / 8;
  localparam int DEPTH  = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [ADDR_W:0]   word_count;
  logic [7:0]        s_data;
  logic              s_valid;
  logic              s_ready;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [N-1:0]      wdata;
  logic              busy;
  logic              cpu_hold;
  logic              done;
  logic              err;

  imem_loader #(.N(N), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .word_count (word_count),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .busy       (busy),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int           addr;
    logic [N-1:0] data;
  } wr_t;

  wr_t          wr_q[$];
  int           ready_seen = 0;
  int           bad_cycles = 0;
  logic [N-1:0] last_word  = '0;

  always @(posedge clk) cyc++;

  // Passive monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (we) wr_q.push_back('{int'(waddr), wdata});
    if (s_ready) ready_seen++;
    if (cpu_hold !== busy || (we && s_ready)) bad_cycles++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic r;
    s_data  = b;
    s_valid = 1'b1;
    for (int t = 0; t < 50; t++) begin
      r = s_ready;
      tick();
      if (r) begin
        s_valid = 1'b0;
        return;
      end
    end
    s_valid = 1'b0;
    check("byte_accept_timeout", 0, 1);
  endtask

  // Runs one complete load and compares it with the model.
  task automatic run_load(input string tag, input int cnt, input logic [7:0] bq[$],
                          input bit gaps, input bit restart, input logic [7:0] chk_byte);
    int           n;
    int           start_cyc;
    int           elapsed;
    logic [7:0]   sum;
    logic         exp_err;
    logic [N-1:0] exp_words[$];
    logic [N-1:0] w;

    n = (cnt > DEPTH) ? DEPTH : cnt;
    sum = 8'h00;
    for (int i = 0; i < n; i++) begin
      w = '0;
      for (int k = 0; k < BPW; k++) begin
        w   = w | (N'(bq[i*BPW + k]) << (8*k));
        sum = sum + bq[i*BPW + k];
      end
      exp_words.push_back(w);
    end
    exp_err = CHK_EN && (n > 0) && (8'(sum + chk_byte) != 8'h00);

    wr_q.delete();
    bad_cycles = 0;
    word_count = (ADDR_W+1)'(cnt);
    start = 1'b1;
    tick();
    start = 1'b0;
    start_cyc = cyc;

    for (int i = 0; i < n*BPW; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) tick();
      end
      if (restart && i == 2) begin
        word_count = (ADDR_W+1)'(1);
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      send_byte(bq[i]);
    end
    if (CHK_EN && n > 0) send_byte(chk_byte);

    for (int t = 0; t < 20 && !done; t++) tick();
    elapsed = cyc - start_cyc;

    check({tag, "_done"}, done, 1);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_s_ready"}, s_ready, 0);
    check({tag, "_nwrites"}, wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), wr_q[i].addr, i);
      check($sformatf("%s_data%0d", tag, i), wr_q[i].data, exp_words[i]);
    end
    if (n > 0) last_word = exp_words[n-1];
    check({tag, "_waddr_end"}, waddr, n % DEPTH);
    check({tag, "_wdata_hold"}, wdata, last_word);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_hold_invariant"}, bad_cycles, 0);
    if (!gaps && !restart)
      check({tag, "_latency"}, elapsed, n*(BPW+1) + ((CHK_EN && n > 0) ? 1 : 0));
  endtask

  initial begin
    logic [7:0] bq[$];
    int         cnt;

    reset      = 1'b0;
    start      = 1'b0;
    word_count = '0;
    s_data     = 8'hA5;
    s_valid    = 1'b1;
    tick();
    tick();
    check("rst_s_ready", s_ready, 0);
    check("rst_we", we, 0);
    check("rst_busy", busy, 0);
    check("rst_cpu_hold", cpu_hold, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_waddr", waddr, 0);
    check("rst_wdata", wdata, 0);
    reset   = 1'b1;
    s_valid = 1'b0;
    tick();
    check("idle_s_ready", s_ready, 0);

    bq = '{8'hE1, 8'hFF, 8'h9F, 8'hD2, 8'h01, 8'h00, 8'h00, 8'hF8};
    run_load("two", 2, bq, 1'b0, 1'b0, 8'h00);
    check("two_w0_literal", last_word, 32'hF8000001);

    run_load("gap", 2, bq, 1'b1, 1'b1, 8'h00);

    ready_seen = 0;
    run_load("zero", 0, bq, 1'b0, 1'b0, 8'h00);
    tick();
    check("zero_no_ready", ready_seen, 0);
    check("zero_done_held", done, 1);

    // Reset in the middle of word 0.
    wr_q.delete();
    word_count = (ADDR_W+1)'(2);
    start = 1'b1;
    tick();
    start = 1'b0;
    send_byte(8'h11);
    send_byte(8'h22);
    reset   = 1'b0;
    s_valid = 1'b1;
    tick();
    reset   = 1'b1;
    s_valid = 1'b0;
    check("abort_nwrites", wr_q.size(), 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_waddr", waddr, 0);
    check("abort_wdata", wdata, 0);
    last_word = '0;
    bq = '{8'h41, 8'h55, 8'h95, 8'hD2};
    run_load("after_abort", 1, bq, 1'b0, 1'b0, 8'h00);
    check("after_abort_literal", last_word, 32'hD2955541);

    bq = '{8'h1F, 8'h00, 8'h00, 8'hB4};
    run_load("chk_good", 1, bq, 1'b0, 1'b0, 8'h2D);
    run_load("chk_bad", 1, bq, 1'b0, 1'b0, 8'h2C);

    for (int r = 0; r < 6; r++) begin
      logic [7:0] s;
      cnt = $urandom_range(1, 5);
      bq.delete();
      s = 8'h00;
      for (int i = 0; i < cnt*BPW; i++) begin
        bq.push_back(8'($urandom));
        s = s + bq[i];
      end
      run_load($sformatf("rnd%0d", r), cnt, bq, 1'($urandom_range(0, 1)), 1'b0,
               ($urandom_range(0, 1) != 0) ? 8'(-s) : 8'(~s));
    end

    // Over-range count clamps to full depth; every address written once.
    cnt = $urandom_range(DEPTH + 1, 2*DEPTH - 1);
    bq.delete();
    for (int i = 0; i < DEPTH*BPW; i++) bq.push_back(8'($urandom));
    run_load("clamp", cnt, bq, 1'b0, 1'b0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
